// File: rtl/read_iq_unpack_if.sv
`default_nettype none
// ============================================================================
//  Module      : read_iq_unpack_if
//  Description : FIFO-side bundle for the IQ unpacker: input FWFT FIFO pop
//                side, I and Q output FIFO push sides, and the pair counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface read_iq_unpack_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32
);
  logic                         in_rd_en;
  logic                         in_empty;
  logic        [DIN_WIDTH-1:0]  in_dout;
  logic                         i_wr_en;
  logic                         i_full;
  logic signed [DOUT_WIDTH-1:0] i_din;
  logic                         q_wr_en;
  logic                         q_full;
  logic signed [DOUT_WIDTH-1:0] q_din;
  logic        [31:0]           pair_count;

  // Unpacker side
  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output i_wr_en,
    input  i_full,
    output i_din,
    output q_wr_en,
    input  q_full,
    output q_din,
    output pair_count
  );

  // FIFO / environment side
  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  i_wr_en,
    output i_full,
    input  i_din,
    input  q_wr_en,
    output q_full,
    input  q_din,
    input  pair_count
  );
endinterface
`default_nettype wire

// File: rtl/read_iq_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : read_iq_unpack
//  Description : Pops packed words from an FWFT FIFO, splits each into I/Q
//                pairs (pair 0 in the low bits, I below Q), normalises the
//                sign, quantises by a left shift and pushes I and Q into two
//                output FIFOs in lockstep. Up to one pair per cycle, no
//                bubble between consecutive words.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_iq_unpack #(
  parameter int DIN_WIDTH     = 32,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int DOUT_WIDTH    = 32,
  parameter int QUANT_BITS    = 10,
  parameter int OFFSET_BINARY = 0
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         flush,
  read_iq_unpack_if.master  bus
);

  localparam int PAIRS    = DIN_WIDTH / (2 * SAMPLE_WIDTH);
  localparam int c_idx_w  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int c_slots  = 2 ** c_idx_w;
  localparam int c_pair_w = 2 * SAMPLE_WIDTH;

  localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(PAIRS - 1);
  localparam logic [SAMPLE_WIDTH:0] c_offset   = {2'b01, {(SAMPLE_WIDTH-1){1'b0}}};

  localparam logic [0:0] c_st_load = 1'b0;
  localparam logic [0:0] c_st_emit = 1'b1;

  // Reject word widths that do not hold a whole number of pairs
  if (((DIN_WIDTH % (2 * SAMPLE_WIDTH)) != 0) || (DIN_WIDTH < 2 * SAMPLE_WIDTH)) begin : g_bad_params
    $error("read_iq_unpack: DIN_WIDTH must be a non-zero multiple of 2*SAMPLE_WIDTH");
  end

  logic [0:0]           r_state;
  logic [DIN_WIDTH-1:0] r_word;
  logic [c_idx_w-1:0]   r_idx;
  logic [31:0]          r_pair_count;

  logic                  w_space;
  logic                  w_last;
  logic                  w_write;
  logic                  w_pop;
  logic [c_pair_w-1:0]   w_pairs [c_slots];
  logic [c_pair_w-1:0]   w_pair;
  logic [DOUT_WIDTH-1:0] w_i_quant;
  logic [DOUT_WIDTH-1:0] w_q_quant;

  // Raw sample -> signed, sign-extended, shifted; bits above DOUT_WIDTH drop
  function automatic logic [DOUT_WIDTH-1:0] quantise(input logic [SAMPLE_WIDTH-1:0] raw);
    logic [SAMPLE_WIDTH:0]            v_s;
    logic [DOUT_WIDTH+SAMPLE_WIDTH:0] v_ext;
    if (OFFSET_BINARY != 0) begin
      v_s = {1'b0, raw} - c_offset;
    end else begin
      v_s = {raw[SAMPLE_WIDTH-1], raw};
    end
    v_ext = {{DOUT_WIDTH{v_s[SAMPLE_WIDTH]}}, v_s};
    v_ext = v_ext << QUANT_BITS;
    return v_ext[DOUT_WIDTH-1:0];
  endfunction

  // Pair slots padded to a power of two so the index never runs out of range
  for (genvar k = 0; k < c_slots; k++) begin : g_pairs
    if (k < PAIRS) begin : g_real
      assign w_pairs[k] = r_word[k*c_pair_w +: c_pair_w];
    end else begin : g_pad
      assign w_pairs[k] = '0;
    end
  end

  assign w_pair    = w_pairs[r_idx];
  assign w_i_quant = quantise(w_pair[SAMPLE_WIDTH-1:0]);
  assign w_q_quant = quantise(w_pair[c_pair_w-1:SAMPLE_WIDTH]);

  // Strobes: both output FIFOs need room; reset and flush suppress everything
  always_comb begin
    w_space = !bus.i_full && !bus.q_full;
    w_last  = (r_idx == c_last_idx);
    w_write = !reset && !flush && (r_state == c_st_emit) && w_space;
    w_pop   = !reset && !flush && !bus.in_empty &&
              ((r_state == c_st_load) || (w_write && w_last));
  end

  assign bus.in_rd_en   = w_pop;
  assign bus.i_wr_en    = w_write;
  assign bus.q_wr_en    = w_write;
  assign bus.i_din      = w_write ? w_i_quant : '0;
  assign bus.q_din      = w_write ? w_q_quant : '0;
  assign bus.pair_count = r_pair_count;

  // Word holding, pair sequencing and pair counting
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= c_st_load;
      r_word       <= '0;
      r_idx        <= '0;
      r_pair_count <= '0;
    end else if (flush) begin
      r_state <= c_st_load;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      if (w_write) begin
        r_pair_count <= r_pair_count + 32'd1;
      end
      if (w_pop) begin
        r_word <= bus.in_dout;
      end
      if (r_state == c_st_load) begin
        if (w_pop) begin
          r_idx   <= '0;
          r_state <= c_st_emit;
        end
      end else if (w_write) begin
        if (!w_last) begin
          r_idx <= r_idx + c_idx_w'(1);
        end else if (w_pop) begin
          r_idx <= '0;
        end else begin
          r_state <= c_st_load;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/read_iq_unpack.md
Name: read_iq_unpack

Overview:
Parametrised IQ sample unpacker. It pops packed words from a first-word-fall-through input FIFO and splits each word into one or more I/Q sample pairs. Each sample is sign-normalised and quantised to the fixed-point format, then the I and Q values are pushed into two output FIFOs. It sits at the head of the FM demod chain and supports both 16-bit signed and 8-bit offset-binary sources at up to 1 pair per cycle.

Parameters:
DIN_WIDTH, 32, input FIFO word width; must be a multiple of 2*SAMPLE_WIDTH
SAMPLE_WIDTH, 16, width of one raw I or Q sample (8 or 16)
PAIRS, DIN_WIDTH/(2*SAMPLE_WIDTH), derived; I/Q pairs per input word (localparam)
DOUT_WIDTH, 32, output sample width
QUANT_BITS, 10, left shift applied by quantisation
OFFSET_BINARY, 0, 1 = raw samples are unsigned offset-binary; 2^(SAMPLE_WIDTH-1) is subtracted before quantising

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
flush  in  1  synchronous discard of the held word
in_rd_en  out  1  input FIFO pop
in_empty  in  1  input FIFO empty
in_dout  in  DIN_WIDTH  input FIFO head word (FWFT: valid whenever !in_empty)
i_wr_en  out  1  I FIFO push
i_full  in  1  I FIFO full
i_din  out  DOUT_WIDTH signed  I sample
q_wr_en  out  1  Q FIFO push
q_full  in  1  Q FIFO full
q_din  out  DOUT_WIDTH signed  Q sample
pair_count  out  32  pairs emitted since reset; wraps at 2^32

Behaviour:
- One clock, one synchronous active-high reset. All state is registered on the clock rising edge. in_rd_en, i_wr_en and q_wr_en are combinational from state and FIFO flags.
- Reset values: state=LOAD, word_r=0, idx=0, pair_count=0. While reset is high, all wr_en/rd_en are 0 and i_din/q_din are 0. Reset mid-word drops the held word; no partial pairs are emitted afterwards.
- Word layout: pair k occupies in_dout[k*2*SW +: 2*SW]. I is the low SAMPLE_WIDTH bits of that slice and Q is the high bits. Pair 0 is emitted first.
- Quantise: s = OFFSET_BINARY ? (raw - 2^(SW-1)) : $signed(raw). The result is sign-extended to DOUT_WIDTH and shifted left by QUANT_BITS; bits above DOUT_WIDTH are truncated.
- LOAD state: if !in_empty, assert in_rd_en, latch in_dout into word_r, set idx=0, go to EMIT. Otherwise stay.
- EMIT state:
  - Write happens only when !i_full && !q_full. Both FIFOs are always written in the same cycle; a single FIFO is never written alone.
  - On a write, i_din/q_din = quantised pair idx of word_r, both wr_en=1, pair_count++.
  - If idx<PAIRS-1: idx++.
  - If idx==PAIRS-1 and !in_empty: assert in_rd_en in the same cycle, latch the new word, idx=0, stay in EMIT (no bubble).
  - If idx==PAIRS-1 and in_empty: go to LOAD.
  - If either FIFO is full: hold; no rd_en, no wr_en, word_r and idx unchanged.
- i_din/q_din are 0 in any cycle where wr_en=0.
- Latency: first pair is written 1 cycle after its word is popped, given no backpressure. Sustained throughput is 1 pair/cycle with no gaps between words.
- flush (priority below reset): state goes to LOAD, idx=0. The held word is discarded and no write occurs that cycle. Input is not popped in the flush cycle.
- Simultaneous events:
  - Out-FIFO full while the input has data: nothing is popped.
  - Last pair write plus new word pop happen in the same cycle.
  - Input empty in LOAD: idle with all strobes 0.
- Illegal parameters (DIN_WIDTH not a multiple of 2*SW) cause an elaboration error.

Test Plan:
1. Defaults, in_dout=0xFFFE0003 -> one write: i_din=3072, q_din=-2048; 1 pop, pair_count=1.
2. SW=8, OFFSET_BINARY=1, in_dout=0x80FF7F01 -> pair0 I=-130048, Q=-1024; next cycle pair1 I=130048, Q=0; single pop.
3. SW=8 signed, 4 words queued, no backpressure -> 8 writes on 8 consecutive cycles; pops on cycles 0, 2, 4, 6; pair_count=8.
4. i_full high for 3 cycles mid-word (q_full low) -> no writes/pops and idx held during those cycles; resumes with the correct next pair; I and Q FIFOs receive identical counts.
5. flush asserted while holding pair1 of an SW=8 word -> pair1 is never emitted; next pop restarts at pair0 of the new word.
6. reset pulsed mid-stream -> the following cycle has all strobes 0 and pair_count=0; processing restarts cleanly from the next queued word.
